// File: rtl/noc_traffic_node.sv
// NoC endpoint traffic generator/checker: paced packet sender plus framing/payload checking receiver.
// Optional LFSR-driven receive stalls are enabled with `define NOC_TRAFFIC_NODE_STALL_EN.
module noc_traffic_node #(
  parameter int         FLIT_W    = 64,
  parameter int         X_W       = 4,
  parameter int         Y_W       = 4,
  parameter int         X_ID      = 0,
  parameter int         Y_ID      = 0,
  parameter int         DEST_X_ID = 0,
  parameter int         DEST_Y_ID = 0,
  parameter logic [7:0] HEAD_MARK = 8'hA5,
  parameter logic [7:0] TAIL_MARK = 8'h5A
) (
  input  logic                 noc_clk,
  input  logic                 noc_rst,
  input  logic                 send_start,
  input  logic [15:0]          cfg_num_pkts,
  input  logic [7:0]           cfg_len,
  input  logic [7:0]           cfg_gap,
  output logic                 sender_valid,
  input  logic                 sender_ready,
  output logic [FLIT_W-1:0]    sender_flit,
  output logic                 sender_is_header,
  output logic                 sender_is_tail,
  input  logic                 receive_valid,
  output logic                 receive_ready,
  input  logic [FLIT_W-1:0]    receive_flit,
  input  logic                 receive_is_header,
  input  logic                 receive_is_tail,
  output logic                 send_busy,
  output logic                 send_done,
  output logic [15:0]          rx_pkt_cnt,
  output logic [15:0]          rx_err_cnt,
  output logic [X_W+Y_W-1:0]   rx_last_src,
  output logic [2:0]           send_state_dbg,
  output logic [1:0]           recv_state_dbg
);

  // Handshake: a flit moves on any cycle where valid && ready; the sender holds
  // valid, flit and flags stable until that cycle, and the receiver only consumes then.

  localparam int XY_W   = X_W + Y_W;
  localparam int CTRL_W = 8 + 2 * XY_W + 24;
  localparam logic [XY_W-1:0] OWN_XY  = {X_W'(X_ID), Y_W'(Y_ID)};
  localparam logic [XY_W-1:0] DEST_XY = {X_W'(DEST_X_ID), Y_W'(DEST_Y_ID)};

  function automatic logic [FLIT_W-1:0] ctrl_flit(input logic [7:0] mark,
                                                  input logic [15:0] seq,
                                                  input logic [7:0] len);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[FLIT_W-1 -: CTRL_W] = {mark, OWN_XY, DEST_XY, seq, len};
    return f;
  endfunction

  function automatic logic [FLIT_W-1:0] data_flit(input logic [15:0] seq,
                                                  input logic [15:0] k);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[31:0] = {seq, k};
    return f;
  endfunction

  // ---------------- sender ----------------
  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_DATA, S_TAIL, S_GAP} send_state_t;

  send_state_t s_state;
  logic [15:0] num_q;
  logic [7:0]  len_q;
  logic [7:0]  gap_q;
  logic [15:0] seq_q;
  logic [7:0]  idx_q;
  logic [7:0]  gap_cnt;

  logic        s_xfer;
  logic [15:0] seq_nxt;
  logic [7:0]  idx_nxt;
  logic [7:0]  len_m1;

  assign s_xfer  = sender_valid && sender_ready;
  assign seq_nxt = seq_q + 16'd1;
  assign idx_nxt = idx_q + 8'd1;
  assign len_m1  = len_q - 8'd1;
  assign send_state_dbg = s_state;

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      s_state          <= S_IDLE;
      num_q            <= '0;
      len_q            <= '0;
      gap_q            <= '0;
      seq_q            <= '0;
      idx_q            <= '0;
      gap_cnt          <= '0;
      sender_valid     <= 1'b0;
      sender_flit      <= '0;
      sender_is_header <= 1'b0;
      sender_is_tail   <= 1'b0;
      send_busy        <= 1'b0;
      send_done        <= 1'b0;
    end else begin
      send_done <= 1'b0;
      case (s_state)
        S_IDLE: begin
          if (send_start) begin
            num_q <= cfg_num_pkts;
            len_q <= cfg_len;
            gap_q <= cfg_gap;
            seq_q <= '0;
            idx_q <= '0;
            if (cfg_num_pkts == 16'd0) begin
              send_done <= 1'b1;
            end else begin
              s_state          <= S_HEAD;
              send_busy        <= 1'b1;
              sender_valid     <= 1'b1;
              sender_flit      <= ctrl_flit(HEAD_MARK, 16'd0, cfg_len);
              sender_is_header <= 1'b1;
              sender_is_tail   <= 1'b0;
            end
          end
        end
        S_HEAD: begin
          if (s_xfer) begin
            sender_is_header <= 1'b0;
            if (len_q == 8'd0) begin
              s_state        <= S_TAIL;
              sender_flit    <= ctrl_flit(TAIL_MARK, seq_q, len_q);
              sender_is_tail <= 1'b1;
            end else begin
              s_state     <= S_DATA;
              idx_q       <= '0;
              sender_flit <= data_flit(seq_q, 16'd0);
            end
          end
        end
        S_DATA: begin
          if (s_xfer) begin
            if (idx_q == len_m1) begin
              s_state        <= S_TAIL;
              sender_flit    <= ctrl_flit(TAIL_MARK, seq_q, len_q);
              sender_is_tail <= 1'b1;
            end else begin
              idx_q       <= idx_nxt;
              sender_flit <= data_flit(seq_q, {8'd0, idx_nxt});
            end
          end
        end
        S_TAIL: begin
          if (s_xfer) begin
            sender_is_tail <= 1'b0;
            seq_q          <= seq_nxt;
            if (seq_nxt == num_q) begin
              s_state      <= S_IDLE;
              sender_valid <= 1'b0;
              sender_flit  <= '0;
              send_busy    <= 1'b0;
              send_done    <= 1'b1;
            end else if (gap_q == 8'd0) begin
              s_state          <= S_HEAD;
              sender_flit      <= ctrl_flit(HEAD_MARK, seq_nxt, len_q);
              sender_is_header <= 1'b1;
            end else begin
              s_state      <= S_GAP;
              gap_cnt      <= gap_q;
              sender_valid <= 1'b0;
              sender_flit  <= '0;
            end
          end
        end
        S_GAP: begin
          // gap_cnt counts the remaining idle cycles including the current one
          if (gap_cnt == 8'd1) begin
            s_state          <= S_HEAD;
            sender_valid     <= 1'b1;
            sender_flit      <= ctrl_flit(HEAD_MARK, seq_q, len_q);
            sender_is_header <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {R_HEAD, R_DATA, R_TAIL} recv_state_t;

  recv_state_t     r_state;
  logic [XY_W-1:0] r_src;
  logic [15:0]     r_seq;
  logic [7:0]      r_len;
  logic [7:0]      r_idx;
  logic            r_err;

  logic [7:0]        in_mark;
  logic [XY_W-1:0]   in_src;
  logic [XY_W-1:0]   in_dst;
  logic [15:0]       in_seq;
  logic [7:0]        in_len;
  logic [FLIT_W-1:0] exp_data;
  logic              rx_acc;
  logic              good_head;
  logic              good_tail;
  logic              dst_bad;

  assign in_mark   = receive_flit[FLIT_W-1 -: 8];
  assign in_src    = receive_flit[FLIT_W-9 -: XY_W];
  assign in_dst    = receive_flit[FLIT_W-9-XY_W -: XY_W];
  assign in_seq    = receive_flit[FLIT_W-9-2*XY_W -: 16];
  assign in_len    = receive_flit[FLIT_W-25-2*XY_W -: 8];
  assign exp_data  = data_flit(r_seq, {8'd0, r_idx});
  assign rx_acc    = receive_valid && receive_ready;
  assign good_head = receive_is_header && (in_mark == HEAD_MARK);
  assign good_tail = receive_is_tail && (in_mark == TAIL_MARK) && (in_seq == r_seq);
  assign dst_bad   = (in_dst != OWN_XY);
  assign recv_state_dbg = r_state;

  logic        take_head;
  logic        goto_head;
  logic        data_step;
  logic        data_bad;
  logic        pkt_ok;
  logic [1:0]  err_add;
  logic [16:0] err_sum;

  // A stray header inside a packet costs one error and can also carry a bad dst,
  // so up to two errors may be charged for a single flit.
  always_comb begin
    take_head = 1'b0;
    goto_head = 1'b0;
    data_step = 1'b0;
    data_bad  = 1'b0;
    pkt_ok    = 1'b0;
    err_add   = 2'd0;
    if (rx_acc) begin
      case (r_state)
        R_HEAD: begin
          if (good_head) take_head = 1'b1;
          else           err_add   = 2'd1;
        end
        R_DATA: begin
          if (receive_is_header) begin
            err_add = 2'd1;
            if (good_head) take_head = 1'b1;
            else           goto_head = 1'b1;
          end else if (receive_is_tail) begin
            err_add   = 2'd1;
            goto_head = 1'b1;
          end else begin
            data_step = 1'b1;
            if (receive_flit != exp_data) begin
              data_bad = 1'b1;
              err_add  = 2'd1;
            end
          end
        end
        R_TAIL: begin
          goto_head = 1'b1;
          if (good_tail) pkt_ok  = ~r_err;
          else           err_add = 2'd1;
        end
        default: goto_head = 1'b1;
      endcase
      if (take_head && dst_bad) err_add = err_add + 2'd1;
    end
  end

  assign err_sum = {1'b0, rx_err_cnt} + {15'd0, err_add};

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      r_state     <= R_HEAD;
      r_src       <= '0;
      r_seq       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_err       <= 1'b0;
      rx_pkt_cnt  <= '0;
      rx_err_cnt  <= '0;
      rx_last_src <= '0;
    end else begin
      if (take_head) begin
        r_src   <= in_src;
        r_seq   <= in_seq;
        r_len   <= in_len;
        r_idx   <= '0;
        r_err   <= dst_bad;
        r_state <= (in_len == 8'd0) ? R_TAIL : R_DATA;
      end else if (goto_head) begin
        r_state <= R_HEAD;
      end else if (data_step) begin
        if (data_bad) r_err <= 1'b1;
        if (r_idx == r_len - 8'd1) r_state <= R_TAIL;
        else                       r_idx   <= r_idx + 8'd1;
      end
      if (pkt_ok) begin
        rx_pkt_cnt  <= rx_pkt_cnt + 16'd1;
        rx_last_src <= r_src;
      end
      rx_err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

`ifdef NOC_TRAFFIC_NODE_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11; ready is low when both low bits are set.
  logic [15:0] lfsr;

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      lfsr          <= 16'hACE1;
      receive_ready <= 1'b0;
    end else begin
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      receive_ready <= ~(lfsr[1] & lfsr[0]);
    end
  end
`else
  always_ff @(posedge noc_clk) begin
    if (noc_rst) receive_ready <= 1'b0;
    else         receive_ready <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_noc_traffic_node.sv
// Bench for noc_traffic_node: loopback scoreboard runs, direct receiver injection and reset abort.
module tb_noc_traffic_node;
  localparam int FLIT_W = 64;

  logic              noc_clk = 1'b0;
  logic              noc_rst = 1'b1;
  logic              send_start = 1'b0;
  logic [15:0]       cfg_num_pkts = '0;
  logic [7:0]        cfg_len = '0;
  logic [7:0]        cfg_gap = '0;
  logic              sender_valid;
  logic              sender_ready;
  logic [FLIT_W-1:0] sender_flit;
  logic              sender_is_header;
  logic              sender_is_tail;
  logic              receive_valid;
  logic              receive_ready;
  logic [FLIT_W-1:0] receive_flit;
  logic              receive_is_header;
  logic              receive_is_tail;
  logic              send_busy;
  logic              send_done;
  logic [15:0]       rx_pkt_cnt;
  logic [15:0]       rx_err_cnt;
  logic [7:0]        rx_last_src;
  logic [2:0]        send_state_dbg;
  logic [1:0]        recv_state_dbg;

  logic              loop_en = 1'b0;
  logic              bp_ok = 1'b1;
  logic              inj_valid = 1'b0;
  logic [FLIT_W-1:0] inj_flit = '0;
  logic              inj_hdr = 1'b0;
  logic              inj_tail = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [FLIT_W-1:0] exp_q[$];
  logic [1:0]        exp_f_q[$];

  // ---------------- clock / reset / wiring ----------------
  always #5 noc_clk = ~noc_clk;

  assign sender_ready      = loop_en ? (bp_ok && receive_ready) : 1'b1;
  assign receive_valid     = loop_en ? (sender_valid && bp_ok) : inj_valid;
  assign receive_flit      = loop_en ? sender_flit : inj_flit;
  assign receive_is_header = loop_en ? sender_is_header : inj_hdr;
  assign receive_is_tail   = loop_en ? sender_is_tail : inj_tail;

  noc_traffic_node #(
    .FLIT_W(FLIT_W), .X_W(4), .Y_W(4), .X_ID(1), .Y_ID(2),
    .DEST_X_ID(1), .DEST_Y_ID(2), .HEAD_MARK(8'hA5), .TAIL_MARK(8'h5A)
  ) dut (
    .noc_clk(noc_clk), .noc_rst(noc_rst), .send_start(send_start),
    .cfg_num_pkts(cfg_num_pkts), .cfg_len(cfg_len), .cfg_gap(cfg_gap),
    .sender_valid(sender_valid), .sender_ready(sender_ready), .sender_flit(sender_flit),
    .sender_is_header(sender_is_header), .sender_is_tail(sender_is_tail),
    .receive_valid(receive_valid), .receive_ready(receive_ready), .receive_flit(receive_flit),
    .receive_is_header(receive_is_header), .receive_is_tail(receive_is_tail),
    .send_busy(send_busy), .send_done(send_done), .rx_pkt_cnt(rx_pkt_cnt),
    .rx_err_cnt(rx_err_cnt), .rx_last_src(rx_last_src),
    .send_state_dbg(send_state_dbg), .recv_state_dbg(recv_state_dbg)
  );

  // ---------------- reference flit formats ----------------
  function automatic logic [63:0] m_ctrl(input logic [7:0] mark, input logic [7:0] src,
                                         input logic [7:0] dst, input logic [15:0] seq,
                                         input logic [7:0] len);
    return {mark, src, dst, seq, len, 16'h0000};
  endfunction

  function automatic logic [63:0] m_data(input logic [15:0] seq, input logic [15:0] k);
    return {32'h0, seq, k};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset;
    noc_rst = 1'b1; send_start = 1'b0; loop_en = 1'b0; inj_valid = 1'b0; bp_ok = 1'b1;
    repeat (2) @(negedge noc_clk);
    noc_rst = 1'b0;
    @(negedge noc_clk);
  endtask

  task automatic drive_rx(input logic [63:0] f, input logic h, input logic t);
    int b;
    b = 0;
    loop_en = 1'b0; inj_valid = 1'b1; inj_flit = f; inj_hdr = h; inj_tail = t;
    while (!receive_ready && b < 200) begin
      @(negedge noc_clk);
      b++;
    end
    if (b >= 200) begin
      checks++; errors++;
      $display("FAIL drive_rx timeout: receive_ready=%b, required 1 within 200 cycles", receive_ready);
    end
    @(negedge noc_clk);
    inj_valid = 1'b0; inj_hdr = 1'b0; inj_tail = 1'b0;
  endtask

  task automatic tx_pkt(input logic [7:0] src, input logic [7:0] dst, input logic [15:0] seq,
                        input int len, input int bad_idx, input logic [15:0] bad_k,
                        input logic [15:0] tail_seq);
    drive_rx(m_ctrl(8'hA5, src, dst, seq, 8'(len)), 1'b1, 1'b0);
    for (int k = 0; k < len; k++)
      drive_rx(m_data(seq, (k == bad_idx) ? bad_k : 16'(k)), 1'b0, 1'b0);
    drive_rx(m_ctrl(8'h5A, src, dst, tail_seq, 8'(len)), 1'b0, 1'b1);
  endtask

  // Loopback run with scoreboard: sender output feeds the receiver through bp_ok gating.
  // bp_mode 0: always ready, 1: pattern 1,0,0,1, 2: random ~75% ready.
  task automatic run_loop(input string name, input int num, input int len, input int gap,
                          input int bp_mode, input bit spurious,
                          output int low_cycles, output int total_cycles);
    int c, flits, done_cnt, done_cycle, after;
    logic xfer, hold;
    logic [FLIT_W-1:0] hold_flit, ef;
    logic [1:0] hold_f, ef_f;
    exp_q.delete(); exp_f_q.delete();
    for (int p = 0; p < num; p++) begin
      exp_q.push_back(m_ctrl(8'hA5, 8'h12, 8'h12, 16'(p), 8'(len))); exp_f_q.push_back(2'b10);
      for (int k = 0; k < len; k++) begin
        exp_q.push_back(m_data(16'(p), 16'(k))); exp_f_q.push_back(2'b00);
      end
      exp_q.push_back(m_ctrl(8'h5A, 8'h12, 8'h12, 16'(p), 8'(len))); exp_f_q.push_back(2'b01);
    end
    low_cycles = 0; c = 0; flits = 0; done_cnt = 0; done_cycle = -1; after = -1;
    hold = 1'b0; hold_flit = '0; hold_f = '0;
    loop_en = 1'b1; bp_ok = 1'b1;
    cfg_num_pkts = 16'(num); cfg_len = 8'(len); cfg_gap = 8'(gap); send_start = 1'b1;
    @(negedge noc_clk);
    send_start = 1'b0;
    while (after != 0 && c < 20000) begin
      send_start = 1'b0;
      case (bp_mode)
        0:       bp_ok = 1'b1;
        1:       bp_ok = (c % 4 == 0) || (c % 4 == 3);
        default: bp_ok = ($urandom_range(0, 3) != 0);
      endcase
      if (!receive_ready) low_cycles++;
      xfer = sender_valid && bp_ok && receive_ready;
      if (hold) begin
        checks++;
        if (sender_valid !== 1'b1 || sender_flit !== hold_flit ||
            {sender_is_header, sender_is_tail} !== hold_f) begin
          errors++;
          $display("FAIL %s hold c=%0d: valid=%b flit=%h flags=%b, required valid=1 flit=%h flags=%b",
                   name, c, sender_valid, sender_flit, {sender_is_header, sender_is_tail}, hold_flit, hold_f);
        end
      end
      hold = sender_valid && !xfer;
      hold_flit = sender_flit; hold_f = {sender_is_header, sender_is_tail};
      if (send_done) begin
        done_cnt++;
        if (after < 0) begin
          done_cycle = c; after = 4;
        end
      end
      if (xfer) begin
        flits++; checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra flit: got %h, required none", name, sender_flit);
        end else begin
          ef = exp_q.pop_front(); ef_f = exp_f_q.pop_front();
          if (sender_flit !== ef || {sender_is_header, sender_is_tail} !== ef_f) begin
            errors++;
            $display("FAIL %s flit %0d: got %h flags %b, required %h flags %b",
                     name, flits - 1, sender_flit, {sender_is_header, sender_is_tail}, ef, ef_f);
          end
        end
      end
      if (spurious && c == 3 && send_busy) begin
        cfg_num_pkts = 16'd9; cfg_len = 8'd1; cfg_gap = 8'd0; send_start = 1'b1;
      end
      if (after > 0) after--;
      @(negedge noc_clk);
      c++;
    end
    send_start = 1'b0; loop_en = 1'b0; total_cycles = c;
    checks++;
    if (c >= 20000) begin
      errors++; $display("FAIL %s timeout: send_done not seen in 20000 cycles", name);
    end
    checks++;
    if (flits != num * (len + 2)) begin
      errors++; $display("FAIL %s flit_count: got %0d, required %0d", name, flits, num * (len + 2));
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL %s done_pulses: got %0d, required 1", name, done_cnt);
    end
`ifndef NOC_TRAFFIC_NODE_STALL_EN
    if (bp_mode == 0) begin
      checks++;
      if (done_cycle != ((num == 0) ? 0 : num * (len + 2) + (num - 1) * gap)) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d, required %0d", name, done_cycle,
                 (num == 0) ? 0 : num * (len + 2) + (num - 1) * gap);
      end
    end
`endif
    checks++;
    if (rx_pkt_cnt !== 16'(num)) begin
      errors++; $display("FAIL %s rx_pkt_cnt: got %0d, required %0d", name, rx_pkt_cnt, num);
    end
    checks++;
    if (rx_err_cnt !== 16'd0) begin
      errors++; $display("FAIL %s rx_err_cnt: got %0d, required 0", name, rx_err_cnt);
    end
    checks++;
    if (rx_last_src !== ((num == 0) ? 8'h00 : 8'h12)) begin
      errors++; $display("FAIL %s rx_last_src: got %h, required %h", name, rx_last_src,
                         (num == 0) ? 8'h00 : 8'h12);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    int bad;
    noc_rst = 1'b1;
    repeat (3) @(negedge noc_clk);
    checks++; if (sender_valid !== 1'b0) begin errors++; $display("FAIL reset sender_valid: got %b, required 0", sender_valid); end
    checks++; if (sender_flit !== '0) begin errors++; $display("FAIL reset sender_flit: got %h, required 0", sender_flit); end
    checks++; if ({sender_is_header, sender_is_tail} !== 2'b00) begin errors++; $display("FAIL reset flags: got %b, required 00", {sender_is_header, sender_is_tail}); end
    checks++; if ({send_busy, send_done} !== 2'b00) begin errors++; $display("FAIL reset busy/done: got %b, required 00", {send_busy, send_done}); end
    checks++; if (receive_ready !== 1'b0) begin errors++; $display("FAIL reset receive_ready: got %b, required 0", receive_ready); end
    checks++; if ({rx_pkt_cnt, rx_err_cnt, rx_last_src} !== 40'h0) begin errors++; $display("FAIL reset counters: got %h %h %h, required 0", rx_pkt_cnt, rx_err_cnt, rx_last_src); end
    checks++; if ({send_state_dbg, recv_state_dbg} !== 5'd0) begin errors++; $display("FAIL reset states: got %b %b, required idle", send_state_dbg, recv_state_dbg); end
    noc_rst = 1'b0;
    @(negedge noc_clk);
    checks++; if (receive_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b, required 1", receive_ready); end
`ifndef NOC_TRAFFIC_NODE_STALL_EN
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge noc_clk);
      if (receive_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ready_constant: got %0d low cycles, required 0", bad); end
`endif
  endtask

  task automatic test_loopback;
    int lo, tot;
    do_reset();
    run_loop("loopback", 3, 4, 2, 0, 1'b0, lo, tot);
  endtask

  task automatic test_backpressure;
    int lo, tot;
    do_reset();
    run_loop("backpressure", 3, 4, 2, 1, 1'b0, lo, tot);
  endtask

  task automatic test_zero_len;
    int lo, tot;
    do_reset();
    run_loop("zero_len", 2, 0, 1, 0, 1'b0, lo, tot);
    do_reset();
    run_loop("zero_pkts", 0, 3, 0, 0, 1'b0, lo, tot);
  endtask

  task automatic test_inject;
    int ep, ex, len, bi;
    logic [7:0]  els;
    logic [15:0] seq, bk;
    ep = 0; ex = 0; els = 8'h00;
    do_reset();
    for (int s = 0; s < 10; s++) begin
      case (s)
        0: begin tx_pkt(8'h12, 8'h12, 16'd5, 3, -1, 16'h0, 16'd5); ep++; els = 8'h12; end
        1: begin tx_pkt(8'h12, 8'h12, 16'd6, 4, 2, 16'h0007, 16'd6); ex++; end
        2: begin tx_pkt(8'h12, 8'h33, 16'd7, 1, -1, 16'h0, 16'd7); ex++; end
        3: begin drive_rx(m_data(16'd0, 16'd0), 1'b0, 1'b0); ex++; end
        4: begin
          drive_rx(m_ctrl(8'hA5, 8'h12, 8'h12, 16'd8, 8'd3), 1'b1, 1'b0);
          drive_rx(m_data(16'd8, 16'd0), 1'b0, 1'b0);
          drive_rx(m_ctrl(8'h5A, 8'h12, 8'h12, 16'd8, 8'd3), 1'b0, 1'b1);
          ex++;
        end
        5: begin tx_pkt(8'h12, 8'h12, 16'd9, 0, -1, 16'h0, 16'd10); ex++; end
        6: begin
          drive_rx(m_ctrl(8'hA5, 8'h12, 8'h12, 16'd11, 8'd2), 1'b1, 1'b0);
          drive_rx(m_data(16'd11, 16'd0), 1'b0, 1'b0);
          tx_pkt(8'h47, 8'h12, 16'd12, 1, -1, 16'h0, 16'd12);
          ex++; ep++; els = 8'h47;
        end
        default: begin
          len = $urandom_range(1, 6);
          seq = 16'($urandom);
          bi = -1; bk = 16'h0;
          if ($urandom_range(0, 1) == 1) begin
            bi = $urandom_range(0, len - 1);
            bk = 16'(bi) ^ (16'd1 << $urandom_range(0, 15));
            ex++;
          end else begin
            ep++; els = 8'h12;
          end
          tx_pkt(8'h12, 8'h12, seq, len, bi, bk, seq);
        end
      endcase
      @(negedge noc_clk);
      checks++; if (rx_err_cnt !== 16'(ex)) begin errors++; $display("FAIL inject%0d rx_err_cnt: got %0d, required %0d", s, rx_err_cnt, ex); end
      checks++; if (rx_pkt_cnt !== 16'(ep)) begin errors++; $display("FAIL inject%0d rx_pkt_cnt: got %0d, required %0d", s, rx_pkt_cnt, ep); end
      checks++; if (rx_last_src !== els) begin errors++; $display("FAIL inject%0d rx_last_src: got %h, required %h", s, rx_last_src, els); end
    end
  endtask

  task automatic test_reset_mid;
    int b, lo, tot;
    do_reset();
    loop_en = 1'b1; bp_ok = 1'b1;
    cfg_num_pkts = 16'd3; cfg_len = 8'd4; cfg_gap = 8'd0; send_start = 1'b1;
    @(negedge noc_clk);
    send_start = 1'b0;
    b = 0;
    while (!(sender_valid && !sender_is_header && !sender_is_tail) && b < 50) begin
      @(negedge noc_clk);
      b++;
    end
    checks++; if (b >= 50) begin errors++; $display("FAIL reset_mid reach_data: waited %0d cycles, required < 50", b); end
    noc_rst = 1'b1;
    @(negedge noc_clk);
    checks++;
    if ({sender_valid, sender_is_header, sender_is_tail, send_busy, send_done, receive_ready} !== 6'b0 ||
        sender_flit !== '0 || {rx_pkt_cnt, rx_err_cnt, rx_last_src} !== 40'h0) begin
      errors++;
      $display("FAIL reset_mid outputs: valid=%b flit=%h busy=%b done=%b rdy=%b pkt=%0d err=%0d, required all 0",
               sender_valid, sender_flit, send_busy, send_done, receive_ready, rx_pkt_cnt, rx_err_cnt);
    end
    noc_rst = 1'b0; loop_en = 1'b0;
    @(negedge noc_clk);
    run_loop("after_reset", 3, 4, 0, 0, 1'b0, lo, tot);
  endtask

  task automatic test_random;
    int lo, tot;
    for (int i = 0; i < 4; i++) begin
      do_reset();
      run_loop($sformatf("random%0d", i), $urandom_range(1, 4), $urandom_range(0, 5),
               $urandom_range(0, 3), 2, 1'b1, lo, tot);
    end
  endtask

`ifdef NOC_TRAFFIC_NODE_STALL_EN
  task automatic test_stall;
    int lo, tot;
    do_reset();
    run_loop("stall", 100, 8, 0, 0, 1'b0, lo, tot);
    checks++;
    if (lo * 100 < tot * 20 || lo * 100 > tot * 30) begin
      errors++; $display("FAIL stall ratio: got %0d low of %0d cycles, required 20-30%%", lo, tot);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_backpressure();
    test_zero_len();
    test_inject();
    test_reset_mid();
    test_random();
`ifdef NOC_TRAFFIC_NODE_STALL_EN
    test_stall();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
